// File: rtl/thumb_imm_pkg.sv
// Shared types and constants for the Thumb-2 modified-immediate encoder.
package thumb_imm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StSearch,
        StDone
    } state_e;

    localparam int unsigned ROT_FIRST = 8;
    localparam int unsigned ROT_LAST  = 31;

    localparam logic [1:0] FORM_PLAIN   = 2'b00;
    localparam logic [1:0] FORM_HALF    = 2'b01;
    localparam logic [1:0] FORM_HALF_HI = 2'b10;
    localparam logic [1:0] FORM_ALL     = 2'b11;

endpackage

// File: rtl/thumb_imm_rot_match.sv
// Combinational test of one rotation: does ROL(v, r) fit the {1, imm7} pattern.
module thumb_imm_rot_match (
    input  logic [31:0] v,
    input  logic [4:0]  r,
    output logic        hit,
    output logic [6:0]  imm7
);

    logic [63:0] v_dbl;
    logic [31:0] w;

    // Upper half of the doubled word shifted left is ROL(v, r).
    assign v_dbl = {v, v} << r;
    assign w     = v_dbl[63:32];
    assign hit   = (w[31:8] == 24'h0) && w[7];
    assign imm7  = w[6:0];

endmodule

// File: rtl/thumb_encode_imm.sv
// Iterative encoder from a 32-bit constant to the Thumb-2 modified-immediate imm12 field.
module thumb_encode_imm
    import thumb_imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] imm12,
    output logic        encodable,
    output logic        rotated
);

    state_e      state_q, state_d;
    logic [31:0] v_q, v_d;
    logic [4:0]  r_q, r_d;
    logic [11:0] imm12_q, imm12_d;
    logic        enc_q, enc_d;
    logic        rot_q, rot_d;
    logic        out_valid_q, out_valid_d;

    logic        rot_hit;
    logic [6:0]  rot_imm7;
    logic [7:0]  b_lo, b_hi;

    assign b_lo = v_q[7:0];
    assign b_hi = v_q[15:8];

    thumb_imm_rot_match u_rot_match (
        .v    (v_q),
        .r    (r_q),
        .hit  (rot_hit),
        .imm7 (rot_imm7)
    );

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        r_d         = r_q;
        imm12_d     = imm12_q;
        enc_d       = enc_q;
        rot_d       = rot_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    v_d     = value;
                    imm12_d = 12'h0;
                    enc_d   = 1'b0;
                    rot_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StDone;
                enc_d   = 1'b1;
                rot_d   = 1'b0;
                if (v_q == {24'h0, b_lo}) begin
                    imm12_d = {2'b00, FORM_PLAIN, b_lo};
                end else if (v_q == {8'h0, b_lo, 8'h0, b_lo} && b_lo != 8'h0) begin
                    imm12_d = {2'b00, FORM_HALF, b_lo};
                end else if (v_q == {b_hi, 8'h0, b_hi, 8'h0} && b_hi != 8'h0) begin
                    imm12_d = {2'b00, FORM_HALF_HI, b_hi};
                end else if (v_q == {4{b_lo}} && b_lo != 8'h0) begin
                    imm12_d = {2'b00, FORM_ALL, b_lo};
                end else begin
                    enc_d   = 1'b0;
                    r_d     = 5'(ROT_FIRST);
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (rot_hit) begin
                    imm12_d = {r_q, rot_imm7};
                    enc_d   = 1'b1;
                    rot_d   = 1'b1;
                    state_d = StDone;
                end else if (r_q == 5'(ROT_LAST)) begin
                    imm12_d = 12'h0;
                    enc_d   = 1'b0;
                    rot_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    r_d = r_q + 5'd1;
                end
            end
            StDone: begin
                // Result registers settle on entry; out_valid follows one cycle later.
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            v_q         <= 32'h0;
            r_q         <= 5'h0;
            imm12_q     <= 12'h0;
            enc_q       <= 1'b0;
            rot_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            r_q         <= r_d;
            imm12_q     <= imm12_d;
            enc_q       <= enc_d;
            rot_q       <= rot_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign imm12     = imm12_q;
    assign encodable = enc_q;
    assign rotated   = rot_q;

endmodule

// File: tb/tb_thumb_encode_imm.sv
// Directed and round-trip bench for the Thumb-2 modified-immediate encoder.
module tb_thumb_encode_imm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] imm12;
    logic        encodable;
    logic        rotated;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    thumb_encode_imm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm12     (imm12),
        .encodable (encodable),
        .rotated   (rotated)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ThumbExpandImm; bit 32 flags a defined (non-UNPREDICTABLE) encoding.
    function automatic logic [32:0] expand(input logic [11:0] imm);
        logic [7:0]  b;
        logic [31:0] u;
        int          sh;
        b = imm[7:0];
        if (imm[11:10] == 2'b00) begin
            case (imm[9:8])
                2'b00:   return {1'b1, 24'h0, b};
                2'b01:   return {(b != 8'h0), 8'h0, b, 8'h0, b};
                2'b10:   return {(b != 8'h0), b, 8'h0, b, 8'h0};
                default: return {(b != 8'h0), b, b, b, b};
            endcase
        end
        u  = {24'h0, 1'b1, imm[6:0]};
        sh = int'(imm[11:7]);
        return {1'b1, (u >> sh) | (u << (32 - sh))};
    endfunction

    function automatic bit has_encoding(input logic [31:0] v);
        logic [32:0] e;
        for (int i = 0; i < 4096; i++) begin
            e = expand(12'(i));
            if (e[32] && e[31:0] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Issue one request, wait for the result, stall the consumer, then hand it off.
    task automatic run_req(input logic [31:0] val, input int stall, input string tag,
                           output logic [11:0] o_imm, output logic o_enc, output logic o_rot,
                           output int lat);
        @(negedge clk);
        check_eq({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        value    = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        value    = $urandom;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        o_imm = imm12;
        o_enc = encodable;
        o_rot = rotated;
        if (!out_valid) begin
            check_eq({tag, ".timeout"}, 32'(out_valid), 32'd1);
        end else begin
            check_eq({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                check_eq({tag, ".stall_hold"}, {17'h0, out_valid, encodable, rotated, imm12},
                         {17'h0, 1'b1, o_enc, o_rot, o_imm});
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_eq({tag, ".after_hs"}, {30'h0, in_ready, out_valid}, {30'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic directed(input logic [31:0] val, input logic [11:0] e_imm, input logic e_enc,
                            input logic e_rot, input int e_lat, input int stall,
                            input string tag);
        logic [11:0] g_imm;
        logic        g_enc, g_rot;
        int          g_lat;
        run_req(val, stall, tag, g_imm, g_enc, g_rot, g_lat);
        check_eq({tag, ".latency"}, 32'(g_lat), 32'(e_lat));
        check_eq({tag, ".imm12"}, 32'(g_imm), 32'(e_imm));
        check_eq({tag, ".encodable"}, 32'(g_enc), 32'(e_enc));
        check_eq({tag, ".rotated"}, 32'(g_rot), 32'(e_rot));
    endtask

    initial begin
        logic [11:0] g_imm;
        logic        g_enc, g_rot;
        int          g_lat;
        logic [31:0] rv, b32;
        logic [32:0] e;
        int          sh;

        rst       = 1'b1;
        in_valid  = 1'b0;
        value     = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset.in_ready", 32'(in_ready), 32'd1);
        check_eq("reset.outs", {19'h0, out_valid, encodable, rotated, imm12}, 32'h0);

        directed(32'h0000_00AB, 12'h0AB, 1'b1, 1'b0, 2, 0, "plain_ab");
        directed(32'h0000_0000, 12'h000, 1'b1, 1'b0, 2, 0, "zero");
        directed(32'h00AB_00AB, 12'h1AB, 1'b1, 1'b0, 2, 1, "half_ab");
        directed(32'hAB00_AB00, 12'h2AB, 1'b1, 1'b0, 2, 0, "half_hi_ab");
        directed(32'hABAB_ABAB, 12'h3AB, 1'b1, 1'b0, 2, 2, "all_ab");
        directed(32'h00FF_00FF, 12'h1FF, 1'b1, 1'b0, 2, 0, "half_ff");
        directed(32'hFF00_0000, 12'h47F, 1'b1, 1'b1, 3, 0, "rot8");
        directed(32'h0000_AB00, 12'hC2B, 1'b1, 1'b1, 19, 0, "rot24");
        directed(32'h0000_01FE, 12'hFFF, 1'b1, 1'b1, 26, 0, "rot31");
        directed(32'h0000_0100, 12'hF80, 1'b1, 1'b1, 26, 0, "rot31_min");
        directed(32'h0000_0101, 12'h000, 1'b0, 1'b0, 26, 0, "unenc_101");
        directed(32'h1234_5678, 12'h000, 1'b0, 1'b0, 26, 5, "unenc_stall");

        // Reset in the middle of a rotation search discards the request.
        @(negedge clk);
        in_valid = 1'b1;
        value    = 32'h1234_5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("midrst.in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst.outs", {19'h0, out_valid, encodable, rotated, imm12}, 32'h0);
        directed(32'h0000_00AB, 12'h0AB, 1'b1, 1'b0, 2, 0, "post_rst");

        // Round-trip sweep against the expansion model.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                rv = $urandom;
            end else begin
                b32 = 32'($urandom_range(0, 255));
                sh  = $urandom_range(0, 31);
                rv  = (b32 << sh) | (b32 >> (32 - sh));
            end
            run_req(rv, $urandom_range(0, 3), "sweep", g_imm, g_enc, g_rot, g_lat);
            if (g_enc) begin
                e = expand(g_imm);
                check_eq("sweep.roundtrip", e[31:0], rv);
                check_eq("sweep.defined", 32'(e[32]), 32'd1);
                check_eq("sweep.rotated", 32'(g_rot), 32'(g_imm[11:10] != 2'b00));
            end else begin
                check_eq("sweep.no_encoding", 32'(has_encoding(rv)), 32'd0);
                check_eq("sweep.unenc_outs", {19'h0, g_rot, g_imm}, 32'h0);
                check_eq("sweep.unenc_lat", 32'(g_lat), 32'd26);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
